mem_burst_arbiter: RTL and testbench

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rr_picker.sv | 32 +++
 rtl/mem_burst_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory burst arbiter.
// Holds the FSM state encoding and the byte-offset width of a 32-bit word address.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Byte address bits below a 32-bit word.
  localparam int BYTE_OFF_BITS = 2;

  // Word address of the start of the line containing byte address a.
  function automatic logic [31:0] line_word_addr(input logic [31:0] a, input int line_bits);
    logic [31:0] mask;
    mask = ~((32'd1 << line_bits) - 32'd1);
    return (a & mask) >> BYTE_OFF_BITS;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: grants the first requester strictly after `last`, wrapping at N.
// Purely combinational, zero latency; no flow control of its own.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, last} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found             = 1'b1;
        gnt[pos[IW-1:0]]  = 1'b1;
        idx               = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter serialising cache line fills/write-backs onto one memory port; grant one cycle after REQ,
// one word per MM_VALID, BURST_LEN+2 cycles minimum per burst. MEM_ARB_WRITE_PRIORITY_EN puts write-backs ahead of fills.
module mem_burst_arbiter
  import mem_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int WORD_SIZE = 32,
  parameter  int BURST_LEN = 8,
  localparam int PW        = $clog2(NUM_PORTS),
  localparam int IW        = $clog2(BURST_LEN)
) (
  input  logic                           MEM_CLK,
  input  logic                           RST_N,
  input  logic [NUM_PORTS-1:0]           REQ,
  input  logic [NUM_PORTS-1:0]           REQ_WE,
  input  logic [NUM_PORTS*32-1:0]        REQ_ADDR,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] REQ_WDATA,
  output logic [NUM_PORTS-1:0]           GNT,
  output logic [NUM_PORTS-1:0]           RVALID,
  output logic [NUM_PORTS-1:0]           WNEXT,
  output logic [NUM_PORTS-1:0]           DONE,
  output logic [WORD_SIZE-1:0]           RDATA,
  output logic [IW-1:0]                  WORD_IDX,
  output logic                           BUSY,
  output logic                           MM_RE,
  output logic                           MM_WE,
  output logic [31:0]                    MM_ADDR,
  output logic [WORD_SIZE-1:0]           MM_DIN,
  input  logic [WORD_SIZE-1:0]           MM_DOUT,
  input  logic                           MM_VALID
);

  localparam int LINE_BITS = IW + BYTE_OFF_BITS;

  logic [31:0]          addr_arr  [NUM_PORTS];
  logic [WORD_SIZE-1:0] wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = REQ_ADDR[i*32 +: 32];
    assign wdata_arr[i] = REQ_WDATA[i*WORD_SIZE +: WORD_SIZE];
  end

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 mm_re_q, mm_re_d;
  logic                 mm_we_q, mm_we_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        win_q, win_d;
  logic [PW-1:0]        last_q, last_d;
  logic [31:0]          mm_addr_q, mm_addr_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  logic [NUM_PORTS-1:0] arb_req;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 rd_beat;
  logic                 wr_beat;
  logic                 last_word;

  always_comb begin
    arb_req = REQ;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    if (|(REQ & REQ_WE)) arb_req = REQ & REQ_WE;
`endif
  end

  rr_picker #(
    .N  (NUM_PORTS),
    .IW (PW)
  ) u_rr_picker (
    .req  (arb_req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign rd_beat   = (state_q == READ)  && MM_VALID;
  assign wr_beat   = (state_q == WRITE) && MM_VALID;
  assign last_word = (idx_q == IW'(BURST_LEN - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    busy_d    = busy_q;
    mm_re_d   = mm_re_q;
    mm_we_d   = mm_we_q;
    idx_d     = idx_q;
    win_d     = win_q;
    last_d    = last_q;
    mm_addr_d = mm_addr_q;
    rdata_d   = rd_beat ? MM_DOUT : rdata_q;

    // The DONE port shadows the imported literal, so the state is scoped explicitly.
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d   = REQ_WE[pick_idx] ? WRITE : READ;
          gnt_d     = pick_gnt;
          busy_d    = 1'b1;
          mm_re_d   = !REQ_WE[pick_idx];
          mm_we_d   = REQ_WE[pick_idx];
          idx_d     = '0;
          win_d     = pick_idx;
          mm_addr_d = line_word_addr(addr_arr[pick_idx], LINE_BITS);
        end
      end
      READ, WRITE: begin
        if (MM_VALID) begin
          idx_d = idx_q + IW'(1);
          if (last_word) begin
            state_d = mem_pkg::DONE;
            mm_re_d = 1'b0;
            mm_we_d = 1'b0;
            done_d  = gnt_q;
          end
        end
      end
      mem_pkg::DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      mm_re_q   <= 1'b0;
      mm_we_q   <= 1'b0;
      idx_q     <= '0;
      win_q     <= '0;
      last_q    <= PW'(NUM_PORTS - 1);
      mm_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      mm_re_q   <= mm_re_d;
      mm_we_q   <= mm_we_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      last_q    <= last_d;
      mm_addr_q <= mm_addr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Word strobes and fill data track MM_VALID in the same cycle.
  assign RVALID   = rd_beat ? gnt_q : '0;
  assign WNEXT    = wr_beat ? gnt_q : '0;
  assign RDATA    = rd_beat ? MM_DOUT : rdata_q;
  assign MM_DIN   = mm_we_q ? wdata_arr[win_q] : '0;
  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign BUSY     = busy_q;
  assign MM_RE    = mm_re_q;
  assign MM_WE    = mm_we_q;
  assign WORD_IDX = idx_q;
  assign MM_ADDR  = mm_addr_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomised and directed bench for mem_burst_arbiter with a transaction-level reference model.
// Expected read words are queued by the memory model and popped by the monitor on each fill beat.
module tb_mem_burst_arbiter;

  localparam int N  = 2;
  localparam int WS = 32;
  localparam int BL = 8;
  localparam int IW = $clog2(BL);

  logic            MEM_CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    REQ, REQ_WE;
  logic [N*32-1:0] REQ_ADDR;
  logic [N*WS-1:0] REQ_WDATA;
  logic [N-1:0]    GNT, RVALID, WNEXT, DONE;
  logic [WS-1:0]   RDATA, MM_DIN, MM_DOUT;
  logic [IW-1:0]   WORD_IDX;
  logic            BUSY, MM_RE, MM_WE, MM_VALID;
  logic [31:0]     MM_ADDR;

  mem_burst_arbiter #(.NUM_PORTS(N), .WORD_SIZE(WS), .BURST_LEN(BL)) dut (
    .MEM_CLK(MEM_CLK), .RST_N(RST_N), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT), .RVALID(RVALID), .WNEXT(WNEXT), .DONE(DONE),
    .RDATA(RDATA), .WORD_IDX(WORD_IDX), .BUSY(BUSY), .MM_RE(MM_RE), .MM_WE(MM_WE),
    .MM_ADDR(MM_ADDR), .MM_DIN(MM_DIN), .MM_DOUT(MM_DOUT), .MM_VALID(MM_VALID)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int got, input int want);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int p);
    return N'(1) << p;
  endfunction

  // Reference arbitration: scan ports after the last-served one, writers first when prioritised.
  function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] w, input int last);
    logic [N-1:0] cand;
    bit           prio;
    int           p;
    prio = 1'b0;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    prio = 1'b1;
`endif
    cand = r;
    if (prio && (r & w) != '0) cand = r & w;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if ((cand & onehot(p)) != '0) return p;
    end
    return 0;
  endfunction

  // ---------------- memory model ----------------
  int            mem_mode = 2;   // 1: random beats, 2: every cycle, 3: every third cycle
  bit            stray_en = 1'b0;
  int            beat_ph  = 0;
  logic [WS-1:0] rdq[$];

  initial begin
    MM_VALID = 1'b0;
    MM_DOUT  = '0;
    forever begin
      @(posedge MEM_CLK);
      #1;
      MM_VALID = 1'b0;
      MM_DOUT  = $urandom;
      if (RST_N && (MM_RE || MM_WE)) begin
        beat_ph++;
        case (mem_mode)
          2:       MM_VALID = 1'b1;
          3:       MM_VALID = (beat_ph % 3 == 0);
          default: MM_VALID = ($urandom_range(0, 1) == 1);
        endcase
        if (MM_VALID && MM_RE) rdq.push_back(MM_DOUT);
      end else begin
        beat_ph = 0;
        if (stray_en) MM_VALID = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    REQ_WDATA = '0;
    forever begin
      @(posedge MEM_CLK);
      #1;
      for (int p = 0; p < N; p++) REQ_WDATA[p*WS +: WS] = $urandom;
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef enum {M_IDLE, M_BURST, M_DONE} mst_t;
  mst_t          m_st = M_IDLE;
  int            m_last = N - 1;
  int            m_port = 0;
  bit            m_we = 1'b0;
  logic [31:0]   m_addr = '0;
  int            m_cnt = 0;
  logic [WS-1:0] last_rdata = '0;
  logic [WS-1:0] exp_word;
  int            rv_cnt[N];
  int            wn_cnt[N];
  int            done_cnt[N];
  int            glog[$];
  logic [31:0]   g_addr = '0;

  initial for (int p = 0; p < N; p++) begin rv_cnt[p] = 0; wn_cnt[p] = 0; done_cnt[p] = 0; end

  always @(negedge MEM_CLK) begin
    if (!RST_N) begin
      check("rst_gnt", GNT, 0);
      check("rst_busy", BUSY, 0);
      check("rst_mm_en", {MM_RE, MM_WE}, 0);
      check("rst_strobes", {RVALID, WNEXT, DONE}, 0);
      check("rst_word_idx", WORD_IDX, 0);
      check("rst_rdata", RDATA, 0);
      m_st       = M_IDLE;
      m_last     = N - 1;
      last_rdata = '0;
      rdq.delete();
    end else begin
      for (int p = 0; p < N; p++) begin
        if ((RVALID & onehot(p)) != '0) rv_cnt[p]++;
        if ((WNEXT & onehot(p)) != '0) wn_cnt[p]++;
        if ((DONE & onehot(p)) != '0) done_cnt[p]++;
      end
      case (m_st)
        M_IDLE: begin
          check("idle_gnt", GNT, 0);
          check("idle_busy", BUSY, 0);
          check("idle_mm_en", {MM_RE, MM_WE}, 0);
          check("idle_strobes", {RVALID, WNEXT, DONE}, 0);
          check("idle_rdata_hold", RDATA, last_rdata);
          if (REQ != '0) begin
            m_port = model_pick(REQ, REQ_WE, m_last);
            m_we   = ((REQ_WE & onehot(m_port)) != '0);
            m_addr = (REQ_ADDR[m_port*32 +: 32] / (BL * 4)) * BL;
            m_cnt  = 0;
            m_st   = M_BURST;
            glog.push_back(m_port);
          end
        end
        M_BURST: begin
          if (m_cnt == 0) g_addr = MM_ADDR;
          check("burst_gnt", GNT, onehot(m_port));
          check("burst_busy", BUSY, 1);
          check("burst_mm_re", MM_RE, !m_we);
          check("burst_mm_we", MM_WE, m_we);
          check("burst_mm_addr", MM_ADDR, m_addr);
          check("burst_word_idx", WORD_IDX, m_cnt);
          check("burst_done", DONE, 0);
          if (m_we) check("burst_mm_din", MM_DIN, REQ_WDATA[m_port*WS +: WS]);
          if (MM_VALID) begin
            if (!m_we) begin
              if (rdq.size() == 0) begin
                fail_now("rdq_underflow", 0, 1);
                exp_word = 'x;
              end else begin
                exp_word = rdq.pop_front();
              end
              check("rvalid", RVALID, onehot(m_port));
              check("wnext_in_read", WNEXT, 0);
              check("rdata", RDATA, exp_word);
              last_rdata = exp_word;
            end else begin
              check("wnext", WNEXT, onehot(m_port));
              check("rvalid_in_write", RVALID, 0);
              check("rdata_hold_w", RDATA, last_rdata);
            end
            m_cnt++;
            if (m_cnt == BL) m_st = M_DONE;
          end else begin
            check("no_beat_strobes", {RVALID, WNEXT}, 0);
            check("rdata_hold", RDATA, last_rdata);
          end
        end
        default: begin
          check("done_pulse", DONE, onehot(m_port));
          check("done_gnt_subset", GNT & ~onehot(m_port), 0);
          check("done_mm_en", {MM_RE, MM_WE}, 0);
          check("done_strobes", {RVALID, WNEXT}, 0);
          check("done_rdata_hold", RDATA, last_rdata);
          m_last = m_port;
          m_st   = M_IDLE;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int total_done();
    int s = 0;
    for (int p = 0; p < N; p++) s += done_cnt[p];
    return s;
  endfunction

  task automatic wait_dones(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge MEM_CLK);
      #1;
      if (total_done() >= target) return;
    end
    fail_now("wait_done_timeout", total_done(), target);
  endtask

  task automatic wait_rv(input int p, input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge MEM_CLK);
      #1;
      if (rv_cnt[p] >= target) return;
    end
    fail_now("wait_rvalid_timeout", rv_cnt[p], target);
  endtask

  task automatic raise(input int p, input bit we, input logic [31:0] addr);
    REQ_ADDR[p*32 +: 32] = addr;
    REQ_WE[p]            = we;
    REQ[p]               = 1'b1;
  endtask

  int base, base_rv, base_wn, base_d1, exp_first;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N    = 1'b0;
    REQ      = '0;
    REQ_WE   = '0;
    REQ_ADDR = '0;
    repeat (3) @(posedge MEM_CLK);
    #1 RST_N = 1'b1;

    // Port 0 line fill at 0x6024
    mem_mode = 2;
    glog.delete();
    base = total_done(); base_rv = rv_cnt[0];
    @(posedge MEM_CLK); #1 raise(0, 1'b0, 32'h6024);
    wait_dones(base + 1, 100);
    @(posedge MEM_CLK); #1 REQ = '0;
    check("fill_addr", g_addr, 32'h1808);
    check("fill_rvalid_count", rv_cnt[0] - base_rv, BL);
    check("fill_grants", glog.size(), 1);

    // Port 1 write-back with a beat every third cycle
    mem_mode = 3;
    glog.delete();
    base = total_done(); base_wn = wn_cnt[1]; base_rv = rv_cnt[1];
    @(posedge MEM_CLK); #1 raise(1, 1'b1, $urandom);
    wait_dones(base + 1, 200);
    @(posedge MEM_CLK); #1 REQ = '0;
    check("wr_wnext_count", wn_cnt[1] - base_wn, BL);
    check("wr_no_rvalid", rv_cnt[1] - base_rv, 0);
    check("wr_grant_port", (glog.size() == 1) ? glog[0] : -1, 1);

    // Both ports fill, held: alternate grants
    mem_mode = 2;
    glog.delete();
    base = total_done();
    @(posedge MEM_CLK); #1 raise(0, 1'b0, $urandom); raise(1, 1'b0, $urandom);
    wait_dones(base + 4, 200);
    @(posedge MEM_CLK); #1 REQ = '0;
    check("rr_grant_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check($sformatf("rr_grant_%0d", i), glog[i], i % 2);

    // Port 0 fill and port 1 write-back pending together
`ifdef MEM_ARB_WRITE_PRIORITY_EN
    exp_first = 1;
`else
    exp_first = 0;
`endif
    glog.delete();
    base = total_done();
    @(posedge MEM_CLK); #1 raise(0, 1'b0, $urandom); raise(1, 1'b1, $urandom);
    wait_dones(base + 1, 100);
    @(posedge MEM_CLK); #1 if (glog.size() > 0) REQ[glog[0]] = 1'b0;
    wait_dones(base + 2, 100);
    @(posedge MEM_CLK); #1 REQ = '0;
    check("prio_first", (glog.size() > 0) ? glog[0] : -1, exp_first);
    check("prio_second", (glog.size() > 1) ? glog[1] : -1, 1 - exp_first);

    // Reset after the fourth word of a port 1 fill
    glog.delete();
    base = total_done();
    @(posedge MEM_CLK); #1 raise(0, 1'b0, $urandom);
    wait_dones(base + 1, 100);
    @(posedge MEM_CLK); #1 REQ = '0; raise(1, 1'b0, $urandom);
    base_rv = rv_cnt[1];
    wait_rv(1, base_rv + 4, 100);
    base_d1 = done_cnt[1];
    @(posedge MEM_CLK); #2 RST_N = 1'b0;
    #1;
    check("async_rst_mm_re", MM_RE, 0);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_gnt", GNT, 0);
    REQ    = '1;
    REQ_WE = '0;
    repeat (2) @(posedge MEM_CLK);
    glog.delete();
    base = total_done();
    #1 RST_N = 1'b1;
    wait_dones(base + 1, 100);
    @(posedge MEM_CLK); #1 REQ = '0;
    check("post_rst_grant", (glog.size() > 0) ? glog[0] : -1, 0);
    check("rst_no_done_port1", done_cnt[1] - base_d1, 0);

    // Stray MM_VALID while idle, then a fill whose REQ drops mid-burst
    stray_en = 1'b1;
    mem_mode = 1;
    repeat (12) @(posedge MEM_CLK);
    base = total_done(); base_rv = rv_cnt[0];
    #1 raise(0, 1'b0, $urandom);
    wait_rv(0, base_rv + 2, 200);
    @(posedge MEM_CLK); #1 REQ[0] = 1'b0;
    wait_dones(base + 1, 200);
    check("drop_done_count", total_done() - base, 1);
    check("drop_rvalid_count", rv_cnt[0] - base_rv, BL);

    // Random traffic
    base = total_done();
    for (int c = 0; c < 3000; c++) begin
      @(posedge MEM_CLK); #1;
      for (int p = 0; p < N; p++) begin
        if (!REQ[p]) begin
          if ($urandom_range(0, 3) == 0) raise(p, $urandom_range(0, 1) == 1, $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          REQ[p] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          REQ_WE[p]            = ($urandom_range(0, 1) == 1);
          REQ_ADDR[p*32 +: 32] = $urandom;
        end
      end
    end
    REQ = '0;
    repeat (BL * 4 + 10) @(posedge MEM_CLK);
    check("random_bursts_seen", (total_done() - base) > 20, 1);
    check("idle_at_end", {BUSY, GNT}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
